// File: rtl/capture_pkg.sv
// Shared definitions for the ADC capture sequencer.
//   state_e    : FSM encoding, also exported on the state port of capture_sched.
//   LEN_W      : width of the packet-length code.
//   IDLE_W     : width of the inter-packet idle length.
//   pkt_words(): decodes the packet-length code into a word count.
package capture_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StCapt = 3'd1,
    StPkt  = 3'd2,
    StGap  = 3'd3,
    StDone = 3'd4
  } state_e;

  localparam int unsigned PKT_BASE_DEFAULT = 128;
  localparam int unsigned LEN_W            = 2;
  localparam int unsigned IDLE_W           = 16;

  // Packet length is the base length scaled by a power of two (x1, x2, x4, x8).
  function automatic int unsigned pkt_words(input int unsigned base,
                                            input logic [LEN_W-1:0] len);
    return base << len;
  endfunction

endpackage

// File: rtl/capture_pkt_gen.sv
// Packet/gap counters for the capture streamer.
// Holds the read address, the word-in-packet counter, the sampled packet length and the idle
// counter, and produces the valid/sop/eop strobes one cycle after each read issue so they line up
// with the memory read data.
// Ports:
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_clear           : clear all counters (FSM leaving PKT/GAP or aborting)
//   i_issue           : a packet read is issued this cycle
//   i_pkt_load        : sample i_len_cfg (start of a packet)
//   i_gap_load        : sample i_idle_cfg into the idle counter (entry to GAP)
//   i_in_gap          : FSM is in GAP
//   i_len_cfg         : packet length code
//   i_idle_cfg        : idle cycles between packets
//   o_rd_addr         : packet read address
//   o_last_word       : current word counter points at the last word of the packet
//   o_rd_at_end       : read address is the last memory word
//   o_gap_done        : idle count has expired
//   o_valid/o_sop/o_eop : issue strobes delayed by one cycle
module capture_pkt_gen
  import capture_pkg::*;
#(
  parameter int unsigned AW       = 15,
  parameter int unsigned PKT_BASE = PKT_BASE_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_issue,
  input  logic              i_pkt_load,
  input  logic              i_gap_load,
  input  logic              i_in_gap,
  input  logic [LEN_W-1:0]  i_len_cfg,
  input  logic [IDLE_W-1:0] i_idle_cfg,
  output logic [AW-1:0]     o_rd_addr,
  output logic              o_last_word,
  output logic              o_rd_at_end,
  output logic              o_gap_done,
  output logic              o_valid,
  output logic              o_sop,
  output logic              o_eop
);

  // Wide enough for the largest packet (PKT_BASE << 3).
  localparam int unsigned WCW = $clog2(PKT_BASE) + 4;

  logic [AW-1:0]     r_rd_addr;
  logic [WCW-1:0]    r_word_cnt;
  logic [LEN_W-1:0]  r_len;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic              r_valid;
  logic              r_sop;
  logic              r_eop;

  logic [WCW-1:0]    w_last_cnt;
  logic              w_first;
  logic              w_last;

  always_comb begin
    w_last_cnt = WCW'(pkt_words(PKT_BASE, r_len) - 1);
    w_first    = (r_word_cnt == '0);
    w_last     = (r_word_cnt == w_last_cnt);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_rd_addr  <= '0;
      r_word_cnt <= '0;
      r_len      <= '0;
      r_idle_cnt <= '0;
    end else begin
      if (i_issue) begin
        r_rd_addr  <= r_rd_addr + AW'(1);
        r_word_cnt <= w_last ? '0 : r_word_cnt + WCW'(1);
      end
      if (i_pkt_load) begin
        r_len <= i_len_cfg;
      end
      // Loaded with length-1 so GAP lasts exactly i_idle_cfg cycles.
      if (i_gap_load) begin
        r_idle_cnt <= i_idle_cfg - IDLE_W'(1);
      end else if (i_in_gap && (r_idle_cnt != '0)) begin
        r_idle_cnt <= r_idle_cnt - IDLE_W'(1);
      end
    end
  end

  // Strobe pipeline is not cleared by i_clear so the final eop still leaves on entry to DONE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
    end else begin
      r_valid <= i_issue;
      r_sop   <= i_issue && w_first;
      r_eop   <= i_issue && w_last;
    end
  end

  always_comb begin
    o_rd_addr   = r_rd_addr;
    o_last_word = w_last;
    o_rd_at_end = &r_rd_addr;
    o_gap_done  = (r_idle_cnt == '0);
    o_valid     = r_valid;
    o_sop       = r_sop;
    o_eop       = r_eop;
  end

endmodule

// File: rtl/capture_sched.sv
// ADC capture memory sequencer.
// Fills the capture memory from the ADC stream, then either holds it for MDIO readback or streams
// it out as fixed-length packets separated by idle gaps. Owns the FSM and arbitrates the single
// memory read port between the packet streamer and MDIO.
// Ports:
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_cfg_capture_mode           : 0 = hold for MDIO, 1 = stream packets
//   i_cfg_capture_start          : level enable; rising edge arms, low aborts
//   i_cfg_capture_again          : rising edge re-captures from DONE
//   i_cfg_pkt_data_length        : packet words = PKT_BASE << value
//   i_cfg_pkt_idle_length        : idle cycles between packets
//   i_cfg_mdio_read_pulse/addr   : MDIO read request
//   i_adc_valid                  : ADC sample valid
//   o_mem_wr_en/addr             : memory write port
//   o_mem_rd_en/addr, i_mem_rd_data : memory read port (1-cycle latency)
//   i_pkt_ready, o_pkt_*         : packet stream
//   o_mdio_rd_valid/data/err     : MDIO read response
//   o_capture_done, o_busy, o_state : status
module capture_sched
  import capture_pkg::*;
#(
  parameter int unsigned AW       = 15,
  parameter int unsigned DW       = 9,
  parameter int unsigned PKT_BASE = PKT_BASE_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cfg_capture_mode,
  input  logic              i_cfg_capture_start,
  input  logic              i_cfg_capture_again,
  input  logic [LEN_W-1:0]  i_cfg_pkt_data_length,
  input  logic [IDLE_W-1:0] i_cfg_pkt_idle_length,
  input  logic              i_cfg_mdio_read_pulse,
  input  logic [AW-1:0]     i_cfg_mdio_memory_addr,
  input  logic              i_adc_valid,
  output logic              o_mem_wr_en,
  output logic [AW-1:0]     o_mem_wr_addr,
  output logic              o_mem_rd_en,
  output logic [AW-1:0]     o_mem_rd_addr,
  input  logic [DW-1:0]     i_mem_rd_data,
  input  logic              i_pkt_ready,
  output logic              o_pkt_valid,
  output logic              o_pkt_sop,
  output logic              o_pkt_eop,
  output logic [DW-1:0]     o_pkt_data,
  output logic              o_mdio_rd_valid,
  output logic [DW-1:0]     o_mdio_rd_data,
  output logic              o_mdio_rd_err,
  output logic              o_capture_done,
  output logic              o_busy,
  output logic [2:0]        o_state
);

  state_e        r_state;
  state_e        w_state_d;
  logic          r_start_q;
  logic          r_again_q;
  logic [AW-1:0] r_wr_addr;
  logic          r_mdio_valid;
  logic          r_mdio_err;
  logic [DW-1:0] r_pkt_hold;
  logic [DW-1:0] r_mdio_hold;

  logic          w_start_rise;
  logic          w_again_rise;
  logic          w_abort;
  logic          w_issue;
  logic          w_last_issue;
  logic          w_wr_last;
  logic          w_mdio_ok;
  logic          w_mdio_rej;
  logic          w_pkt_load;
  logic          w_gap_load;
  logic          w_gen_clear;
  logic [AW-1:0] w_pkt_rd_addr;
  logic          w_last_word;
  logic          w_rd_at_end;
  logic          w_gap_done;
  logic          w_pkt_valid;
  logic          w_pkt_sop;
  logic          w_pkt_eop;

  always_comb begin
    w_start_rise = i_cfg_capture_start && !r_start_q;
    w_again_rise = i_cfg_capture_again && !r_again_q;
    w_abort      = (r_state != StIdle) && !i_cfg_capture_start;
    // Issue is suppressed on the abort cycle so an aborted packet never emits its eop.
    w_issue      = (r_state == StPkt) && i_pkt_ready && i_cfg_capture_start;
    w_last_issue = w_issue && w_last_word;
    w_wr_last    = (r_state == StCapt) && i_adc_valid && (&r_wr_addr);
    w_mdio_ok    = i_cfg_mdio_read_pulse && ((r_state == StIdle) || (r_state == StDone));
    w_mdio_rej   = i_cfg_mdio_read_pulse && !((r_state == StIdle) || (r_state == StDone));
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (w_start_rise) w_state_d = StCapt;
      StCapt: if (w_wr_last) w_state_d = i_cfg_capture_mode ? StPkt : StDone;
      StPkt: begin
        if (w_last_issue) begin
          if (w_rd_at_end) begin
            w_state_d = StDone;
          end else if (i_cfg_pkt_idle_length != '0) begin
            w_state_d = StGap;
          end else begin
            w_state_d = StPkt;
          end
        end
      end
      StGap:  if (w_gap_done) w_state_d = StPkt;
      StDone: if (w_again_rise) w_state_d = StCapt;
      default: w_state_d = StIdle;
    endcase
    if (w_abort) begin
      w_state_d = StIdle;
    end
  end

  // Length is resampled at every packet start, including back-to-back packets.
  always_comb begin
    w_pkt_load  = (w_state_d == StPkt) && ((r_state != StPkt) || w_last_issue);
    w_gap_load  = (w_state_d == StGap) && (r_state != StGap);
    w_gen_clear = (w_state_d != StPkt) && (w_state_d != StGap);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_start_q <= 1'b0;
      r_again_q <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_start_q <= i_cfg_capture_start;
      r_again_q <= i_cfg_capture_again;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_addr <= '0;
    end else if (w_abort || ((w_state_d == StCapt) && (r_state != StCapt))) begin
      r_wr_addr <= '0;
    end else if ((r_state == StCapt) && i_adc_valid) begin
      r_wr_addr <= r_wr_addr + AW'(1);
    end
  end

  // Read data is presented with its valid and held afterwards.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mdio_valid <= 1'b0;
      r_mdio_err   <= 1'b0;
      r_pkt_hold   <= '0;
      r_mdio_hold  <= '0;
    end else begin
      r_mdio_valid <= w_mdio_ok;
      r_mdio_err   <= w_mdio_rej;
      if (w_pkt_valid) begin
        r_pkt_hold <= i_mem_rd_data;
      end
      if (r_mdio_valid) begin
        r_mdio_hold <= i_mem_rd_data;
      end
    end
  end

  capture_pkt_gen #(
    .AW       (AW),
    .PKT_BASE (PKT_BASE)
  ) u_pkt_gen (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (w_gen_clear),
    .i_issue     (w_issue),
    .i_pkt_load  (w_pkt_load),
    .i_gap_load  (w_gap_load),
    .i_in_gap    (r_state == StGap),
    .i_len_cfg   (i_cfg_pkt_data_length),
    .i_idle_cfg  (i_cfg_pkt_idle_length),
    .o_rd_addr   (w_pkt_rd_addr),
    .o_last_word (w_last_word),
    .o_rd_at_end (w_rd_at_end),
    .o_gap_done  (w_gap_done),
    .o_valid     (w_pkt_valid),
    .o_sop       (w_pkt_sop),
    .o_eop       (w_pkt_eop)
  );

  always_comb begin
    o_mem_wr_en     = (r_state == StCapt) && i_adc_valid;
    o_mem_wr_addr   = r_wr_addr;
    // Streamer and MDIO are never active in the same state, so the port never collides.
    o_mem_rd_en     = w_issue || w_mdio_ok;
    o_mem_rd_addr   = w_mdio_ok ? i_cfg_mdio_memory_addr : w_pkt_rd_addr;
    o_pkt_valid     = w_pkt_valid;
    o_pkt_sop       = w_pkt_sop;
    o_pkt_eop       = w_pkt_eop;
    o_pkt_data      = w_pkt_valid ? i_mem_rd_data : r_pkt_hold;
    o_mdio_rd_valid = r_mdio_valid;
    o_mdio_rd_data  = r_mdio_valid ? i_mem_rd_data : r_mdio_hold;
    o_mdio_rd_err   = r_mdio_err;
    o_capture_done  = (r_state == StDone);
    o_busy          = (r_state == StCapt) || (r_state == StPkt) || (r_state == StGap);
    o_state         = r_state;
  end

endmodule

// File: doc/capture_sched.md
Name: capture_sched

Overview:
- Sequencer for the ADC capture memory, driven by the register fields exported from the control subsystem (capture mode/start/again, packet data/idle length, MDIO read pulse/address).
- Fills the capture memory from the ADC sample stream, then streams it out as fixed-length packets separated by idle gaps, or holds it for MDIO readback.
- Arbitrates the single memory read port between the packet streamer and MDIO readback.

Parameters:
- AW, 15, capture memory address width; depth = 2^AW words.
- DW, 9, memory word width.
- PKT_BASE, 128, packet length in words for cfg_pkt_data_length=0.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- cfg_capture_mode  in  1  0 = capture then hold for MDIO; 1 = capture then stream packets.
- cfg_capture_start  in  1  level enable; rising edge arms; low aborts.
- cfg_capture_again  in  1  rising edge re-captures from DONE.
- cfg_pkt_data_length  in  2  packet words = PKT_BASE << value (128/256/512/1024).
- cfg_pkt_idle_length  in  16  idle cycles between packets.
- cfg_mdio_read_pulse  in  1  one-cycle MDIO read request.
- cfg_mdio_memory_addr  in  AW  MDIO read address.
- adc_valid  in  1  ADC sample valid.
- mem_wr_en  out  1  memory write strobe.
- mem_wr_addr  out  AW  memory write address.
- mem_rd_en  out  1  memory read strobe.
- mem_rd_addr  out  AW  memory read address.
- mem_rd_data  in  DW  memory read data; 1-cycle latency.
- pkt_ready  in  1  downstream can accept.
- pkt_valid  out  1  packet word valid.
- pkt_sop  out  1  first word of packet.
- pkt_eop  out  1  last word of packet.
- pkt_data  out  DW  packet word.
- mdio_rd_valid  out  1  MDIO read data valid.
- mdio_rd_data  out  DW  MDIO read data.
- mdio_rd_err  out  1  MDIO read rejected (port busy).
- capture_done  out  1  high in DONE.
- busy  out  1  high in CAPT/PKT/GAP.
- state  out  3  IDLE=0, CAPT=1, PKT=2, GAP=3, DONE=4.

Behaviour:
- Reset: all outputs 0, state IDLE, start/again edge registers 0, all counters 0.
- Edge detect: start_rise = start & ~start_q; again_rise likewise.
- Abort: cfg_capture_start low in any non-IDLE state -> IDLE next cycle, counters cleared. An in-flight packet ends without pkt_eop.
- IDLE: start_rise -> CAPT, wr_addr=0.
- CAPT: mem_wr_en = adc_valid (combinational), mem_wr_addr = wr counter; counter increments per valid.
  - Write at address 2^AW-1 -> PKT if mode=1, else DONE. rd_addr and word count cleared.
  - Mode is sampled on that last write.
- PKT: each cycle pkt_ready=1 -> issue read at rd_addr, increment rd_addr and word count. No issue when pkt_ready=0.
  - pkt_valid, pkt_sop and pkt_eop are the issue strobes delayed 1 cycle, aligned with mem_rd_data.
  - Downstream must absorb one word after dropping pkt_ready.
  - sop on word 0; eop on word (PKT_BASE<<len)-1.
  - On the last word: if rd_addr was 2^AW-1 -> DONE; else GAP if idle_length != 0, else stay in PKT (back-to-back, next issue is a new sop).
- GAP: count idle_length cycles, then PKT. Length fields are sampled at entry to PKT/GAP.
- DONE: capture_done=1; again_rise -> CAPT with wr_addr=0. start_rise is ignored outside IDLE.
- MDIO read:
  - Accepted in IDLE or DONE: mem_rd_en=1 with cfg_mdio_memory_addr the same cycle; mdio_rd_valid next cycle with mdio_rd_data=mem_rd_data.
  - In CAPT/PKT/GAP: no read, mdio_rd_err pulses 1 cycle later.
  - Same-cycle MDIO pulse and again_rise in DONE: the MDIO read completes and the transition still happens (CAPT does not use the read port).
- Address counters wrap modulo 2^AW. Packet length divides the depth, so the last packet always ends at 2^AW-1.
- mem_rd_data is registered into pkt_data/mdio_rd_data only on the respective valid; otherwise both hold.

Decomposition:
- Shared package capture_pkg: state encoding constants, PKT_BASE default, packet-length decode function.
- One sub-module, capture_pkt_gen: PKT/GAP word and idle counters plus sop/eop/valid generation; the FSM and arbitration stay in the top.

Test Plan:
- AW=8, mode=0: start 0->1, 256 adc_valid -> writes addresses 0..255, state=DONE, capture_done=1; MDIO read addr 0x2A -> mdio_rd_valid 1 cycle later with stored word.
- AW=10, mode=1, len=0, idle=5, pkt_ready=1 -> 8 packets of 128 words with sop/eop, 5 idle cycles between packets, DONE after address 1023.
- Streaming with pkt_ready toggled 1/0 every other cycle -> no skipped or duplicated addresses; eop on the 128th word.
- MDIO pulse during PKT -> mdio_rd_err=1, packet stream undisturbed.
- Start dropped mid-PKT -> IDLE next cycle, no eop; start re-raised -> capture restarts at wr_addr 0.
- idle=0 -> back-to-back packets; again_rise in DONE -> new capture from address 0.
